// File: rtl/gpu_pkg.sv
// Shared GPU rasteriser types: scheduler FSM states and the index/count width
// derivations also used by the active list and the pixel stage.
package gpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } sched_state_t;

  localparam int DEF_RECT_COUNT = 64;
  localparam int DEF_MAX_ACTIVE = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scanline_rect_scheduler_comparator.sv
// Vertical span test shared across all rects: hit when left <= coord < right.
module comparator #(
  parameter int W = 16
) (
  input  logic [W-1:0] left,
  input  logic [W-1:0] right,
  input  logic [W-1:0] coord,
  output logic         hit
);

  // An empty or inverted span (left >= right) can never satisfy both bounds.
  assign hit = (left <= coord) && (coord < right);

endmodule

// File: rtl/scanline_rect_scheduler.sv
// Per-scanline rect culling: walks the rect table once per line and emits the
// ascending indices of rects whose vertical span covers the line.
`ifndef COORD_WIDTH
`define COORD_WIDTH 16
`endif

module scanline_rect_scheduler
  import gpu_pkg::*;
#(
  parameter int COORD_WIDTH = `COORD_WIDTH,
  parameter int RECT_COUNT  = DEF_RECT_COUNT,
  parameter int MAX_ACTIVE  = DEF_MAX_ACTIVE,
  parameter int IDX_W       = idx_width(RECT_COUNT),
  parameter int CNT_W       = cnt_width(MAX_ACTIVE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] line_y,
  output logic [IDX_W-1:0]       rect_addr,
  input  logic [COORD_WIDTH-1:0] rect_top,
  input  logic [COORD_WIDTH-1:0] rect_bottom,
  output logic                   active_we,
  output logic [IDX_W-1:0]       active_idx,
  output logic [CNT_W-1:0]       active_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECT_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ACTIVE);

  sched_state_t           state;
  logic                   drain_cnt;
  logic [COORD_WIDTH-1:0] y_lat;
  logic                   vld_p1;
  logic [IDX_W-1:0]       idx_p1;
  logic                   hit_p1;

  comparator #(.W(COORD_WIDTH)) u_cmp (
    .left  (rect_top),
    .right (rect_bottom),
    .coord (y_lat),
    .hit   (hit_p1)
  );

  // Stage 1: index of the read in flight; lines up with rect_top/rect_bottom.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) y_lat <= line_y;
    idx_p1 <= rect_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      drain_cnt    <= 1'b0;
      rect_addr    <= '0;
      vld_p1       <= 1'b0;
      active_we    <= 1'b0;
      active_idx   <= '0;
      active_count <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done      <= 1'b0;
      active_we <= 1'b0;
      vld_p1    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_SCAN;
            rect_addr    <= '0;
            active_count <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_SCAN: begin
          vld_p1 <= 1'b1;
          if (rect_addr == LAST_IDX) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            rect_addr <= rect_addr + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Stage 2: compare result becomes the active-list write.
      if (vld_p1 && hit_p1) begin
        if (active_count < CNT_MAX) begin
          active_we    <= 1'b1;
          active_idx   <= idx_p1;
          active_count <= active_count + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_scanline_rect_scheduler.sv
// Bench for scanline_rect_scheduler: behavioural scan model plus literal checks.
module tb_scanline_rect_scheduler;

  localparam int CW = 16;
  localparam int RC = 4;
  localparam int MA = 2;
  localparam int IW = 2;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] line_y = '0;
  logic [IW-1:0] rect_addr;
  logic [CW-1:0] rect_top = '0;
  logic [CW-1:0] rect_bottom = '0;
  logic          active_we;
  logic [IW-1:0] active_idx;
  logic [NW-1:0] active_count;
  logic          overflow;
  logic          busy;
  logic          done;

  scanline_rect_scheduler #(
    .COORD_WIDTH(CW), .RECT_COUNT(RC), .MAX_ACTIVE(MA), .IDX_W(IW), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_y(line_y),
    .rect_addr(rect_addr), .rect_top(rect_top), .rect_bottom(rect_bottom),
    .active_we(active_we), .active_idx(active_idx), .active_count(active_count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] tt [RC];
  logic [CW-1:0] bb [RC];

  // Synchronous rect table read port
  always @(posedge clk) begin
    rect_top    <= tt[rect_addr];
    rect_bottom <= bb[rect_addr];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Model: edge counter, accept edge, and the expected writes for that scan
  int edge_n = 0;
  int s_edge = 0;
  bit have_scan = 0;
  int exp_w[$];
  int ovf_i = -1;
  bit chk_en = 0;

  always @(posedge clk) begin
    edge_n++;
    if (rst_n && start &&
        (!have_scan || (edge_n - s_edge) < 1 || (edge_n - s_edge) > RC + 2)) begin
      int n;
      n = 0;
      have_scan = 1;
      s_edge = edge_n;
      exp_w.delete();
      ovf_i = -1;
      for (int i = 0; i < RC; i++) begin
        if (tt[i] <= line_y && line_y < bb[i]) begin
          if (n < MA) begin
            exp_w.push_back(i);
            n++;
          end else if (ovf_i < 0) begin
            ovf_i = i;
          end
        end
      end
    end
  end

  always @(negedge rst_n) have_scan = 0;

  int wlog_cyc[$];
  int wlog_idx[$];
  int done_cyc = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      int rel;
      bit e_we;
      int e_idx;
      int e_cnt;
      bit e_ovf;
      rel = edge_n - s_edge + 1;
      if (!rst_n || !have_scan) begin
        chk("busy_rst", busy, 0);
        chk("done_rst", done, 0);
        chk("we_rst", active_we, 0);
        chk("count_rst", active_count, 0);
        chk("ovf_rst", overflow, 0);
        chk("addr_rst", rect_addr, 0);
        chk("idx_rst", active_idx, 0);
      end else begin
        e_we = 0; e_idx = 0; e_cnt = 0;
        foreach (exp_w[k]) begin
          if (3 + exp_w[k] == rel) begin
            e_we = 1;
            e_idx = exp_w[k];
          end
          if (3 + exp_w[k] <= rel) e_cnt++;
        end
        e_ovf = (ovf_i >= 0) && (3 + ovf_i <= rel);
        chk("busy", busy, int'(rel >= 1 && rel <= RC + 2));
        chk("done", done, int'(rel == RC + 3));
        chk("active_we", active_we, int'(e_we));
        if (e_we) chk("active_idx", active_idx, e_idx);
        chk("active_count", active_count, e_cnt);
        chk("overflow", overflow, int'(e_ovf));
        if (rel >= 1 && rel <= RC) chk("rect_addr", rect_addr, rel - 1);
      end
      if (active_we && rst_n && have_scan) begin
        wlog_cyc.push_back(rel);
        wlog_idx.push_back(int'(active_idx));
      end
      if (done && have_scan) done_cyc = rel;
    end
  end

  task automatic clear_logs();
    wlog_cyc.delete();
    wlog_idx.delete();
    done_cyc = -1;
  endtask

  task automatic set_rect(input int i, input int t, input int b);
    tt[i] = CW'(t);
    bb[i] = CW'(b);
  endtask

  // Called at a negedge; start is sampled at the next edge (edge 0).
  task automatic run_scan(input int y, input int cycles);
    clear_logs();
    start = 1'b1;
    line_y = CW'(y);
    @(negedge clk);
    start = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic load_basic();
    set_rect(0, 10, 20); set_rect(1, 0, 5); set_rect(2, 15, 30); set_rect(3, 40, 50);
  endtask

  initial begin
    for (int i = 0; i < RC; i++) set_rect(i, 0, 0);
    #1 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan, y=15
    load_basic();
    run_scan(15, 10);
    chk("t1_nwrites", wlog_cyc.size(), 2);
    if (wlog_cyc.size() == 2) begin
      chk("t1_w0_cyc", wlog_cyc[0], 3); chk("t1_w0_idx", wlog_idx[0], 0);
      chk("t1_w1_cyc", wlog_cyc[1], 5); chk("t1_w1_idx", wlog_idx[1], 2);
    end
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_count", active_count, 2);
    chk("t1_ovf", overflow, 0);

    // Span boundaries, y=15
    set_rect(0, 15, 16); set_rect(1, 14, 15); set_rect(2, 16, 17); set_rect(3, 15, 15);
    run_scan(15, 10);
    chk("t2_nwrites", wlog_idx.size(), 1);
    if (wlog_idx.size() == 1) chk("t2_idx", wlog_idx[0], 0);
    chk("t2_count", active_count, 1);

    // Overflow: all rects cover y=50
    for (int i = 0; i < RC; i++) set_rect(i, 0, 100);
    run_scan(50, 10);
    chk("t3_nwrites", wlog_idx.size(), 2);
    if (wlog_idx.size() == 2) begin
      chk("t3_idx0", wlog_idx[0], 0); chk("t3_idx1", wlog_idx[1], 1);
    end
    chk("t3_count", active_count, 2);
    chk("t3_ovf", overflow, 1);

    // Mid-scan start ignored; start in done cycle accepted
    load_basic();
    clear_logs();
    start = 1'b1; line_y = 16'd15;
    @(negedge clk);
    start = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);
    @(negedge clk);
    start = 1'b1; line_y = 16'd99;
    @(negedge clk);
    start = 1'b0; line_y = 16'd0;
    repeat (4) @(negedge clk);
    chk("t4_nwrites", wlog_idx.size(), 2);
    if (wlog_idx.size() == 2) begin
      chk("t4_idx0", wlog_idx[0], 0); chk("t4_idx1", wlog_idx[1], 2);
    end
    chk("t4_done", done, 1);
    start = 1'b1; line_y = 16'd15;
    @(negedge clk);
    start = 1'b0;
    chk("t4_restart_addr", rect_addr, 0);
    chk("t4_restart_busy", busy, 1);
    repeat (9) @(negedge clk);
    chk("t4_count2", active_count, 2);

    // Async reset in cycle 3, then a clean scan
    clear_logs();
    start = 1'b1; line_y = 16'd15;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_busy_async", busy, 0);
    chk("t5_count_async", active_count, 0);
    chk("t5_we_async", active_we, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_no_done", done_cyc, -1);
    run_scan(15, 10);
    chk("t5_count_after", active_count, 2);
    chk("t5_done_after", done_cyc, 7);

    // Coordinate extremes
    set_rect(0, 0, 16'hFFFF); set_rect(1, 0, 0); set_rect(2, 5, 5); set_rect(3, 16'hFFFF, 0);
    run_scan(0, 10);
    chk("t6_y0_count", active_count, 1);
    run_scan(16'hFFFF, 10);
    chk("t6_ymax_count", active_count, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
